load_sequencer: RTL and testbench
=================================

LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the width of the count, preset and target.
REQ-002 The block SHALL have parameter TIMEOUT, default 20, giving the maximum number of RUN cycles before the block gives up.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start_valid  input  1  a start request is present.
REQ-006 start_ready  output  1  the block can accept a start request.
REQ-007 preset  input  WIDTH  value to load into the downstream counter; sampled on acceptance.
REQ-008 target  input  WIDTH  count value that ends the run; sampled on acceptance.
REQ-009 abort  input  1  cancels a run in progress.
REQ-010 count  input  WIDTH  current value of the downstream loadable up counter.
REQ-011 load  output  1  load strobe to the counter.
REQ-012 d  output  WIDTH  load data to the counter.
REQ-013 busy  output  1  high in states LOAD and RUN.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 timeout  output  1  qualifies done: high when the run ended by timeout rather than by a target match.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, LOAD, RUN and DONE.
REQ-017 In IDLE, start_ready SHALL be 1; a start is accepted when start_valid=1 and start_ready=1, and on that edge preset and target SHALL be registered into preset_q and target_q and the FSM SHALL move to LOAD.
REQ-018 In every state other than IDLE, start_ready SHALL be 0, and start_valid SHALL be ignored with no queuing.
REQ-019 In LOAD, load SHALL be 1 and d SHALL equal preset_q for exactly one cycle; the next state SHALL be RUN.
REQ-020 In RUN, load SHALL be 0 and a timer SHALL count RUN cycles starting from 0.
REQ-021 In RUN, if count==target_q the next state SHALL be DONE with timeout=0.
REQ-022 In RUN, if the timer equals TIMEOUT-1 without a match, the next state SHALL be DONE with timeout=1.
REQ-023 If a match and the timeout occur in the same cycle, the match SHALL win and timeout SHALL be 0.
REQ-024 Comparison SHALL be modulo 2^WIDTH, so a target below the preset is reached through the counter's wrap from 15 to 0.
REQ-025 If preset==target, the match SHALL occur in the first RUN cycle.
REQ-026 On a match, done SHALL be high in the cycle following edge E0+2+((target-preset) mod 2^WIDTH), where E0 is the acceptance edge.
REQ-027 In DONE, done SHALL be 1 for one cycle, timeout SHALL hold its qualifier, and the next state SHALL be IDLE.
REQ-028 abort=1 in LOAD or RUN SHALL return the FSM to IDLE on the next edge, with no done pulse and load forced to 0.
REQ-029 abort SHALL have no effect in IDLE or DONE.
REQ-030 The outputs load, d, done, timeout and busy SHALL be registered, with no combinational path from any input.
REQ-031 d SHALL hold preset_q from LOAD until the next acceptance.

Reset
REQ-032 Asserting rst SHALL asynchronously force state=IDLE, load=0, d=0, done=0, timeout=0, busy=0, timer=0, preset_q=0 and target_q=0.
REQ-033 Reset in the middle of a run SHALL discard the run with no done pulse.
REQ-034 After rst is released, start_ready SHALL be 1 in the first cycle.

Structure
REQ-035 The state encoding and the default values of WIDTH and TIMEOUT SHALL reside in the shared package upcounter_pkg.
REQ-036 The RUN-cycle timer SHALL be the sub-module timeout_timer (clear, enable, expired); all other logic SHALL be inline.

Verification
REQ-037 Bench: the DUT connected to a behavioural loadable up counter (WIDTH=4, count increments each cycle, load has priority).
REQ-038 Scenario: preset=3, target=7 -> load pulse with d=3, done high 6 edges after acceptance, timeout=0.
REQ-039 Scenario: preset=13, target=2 -> wrap 15->0, done 7 edges after acceptance, timeout=0.
REQ-040 Scenario: preset=9, target=9 -> done 2 edges after acceptance.
REQ-041 Scenario: counter model held in reset during RUN, target=5 -> done with timeout=1 after 20 RUN cycles.
REQ-042 Scenario: abort in the third RUN cycle -> IDLE next edge, no done; a subsequent start with preset=0, target=1 completes normally.
REQ-043 Scenario: rst asserted mid-RUN while start_valid is held -> all outputs 0 immediately; start is accepted in the first cycle after release.

Source files
------------

// File: rtl/upcounter_pkg.sv
// Shared definitions for the load sequencer: FSM encoding and default sizing.
package upcounter_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_TIMEOUT = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/load_sequencer_if.sv
// Start handshake plus the load/count link to the downstream counter.
interface load_sequencer_if #(
    parameter int WIDTH = upcounter_pkg::DEF_WIDTH
) ();
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] target;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             busy;
    logic             done;
    logic             timeout;

    modport master (
        output start_valid, preset, target, abort, count,
        input  start_ready, load, d, busy, done, timeout
    );

    modport slave (
        input  start_valid, preset, target, abort, count,
        output start_ready, load, d, busy, done, timeout
    );
endinterface

// File: rtl/timeout_timer.sv
// Counts enabled cycles from zero; expired flags the TIMEOUT-th enabled cycle.
module timeout_timer #(
    parameter int TIMEOUT = upcounter_pkg::DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer <= '0;
        else if (clear)
            timer <= '0;
        else if (enable)
            timer <= timer + TW'(1);
    end

    assign expired = (timer == TW'(TIMEOUT - 1));
endmodule

// File: rtl/load_sequencer.sv
// Loads a preset into an external up counter, then waits for it to reach
// the target (or time out) and reports completion with a one-cycle pulse.
module load_sequencer
    import upcounter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    load_sequencer_if.slave bus
);
    state_t           state, state_nx;
    logic [WIDTH-1:0] preset_q, target_q;
    logic             accept, match, expired, timeout_nx;

    assign bus.start_ready = (state == IDLE);
    assign accept          = bus.start_valid && (state == IDLE);
    assign match           = (bus.count == target_q);

    timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != RUN),
        .enable  (state == RUN),
        .expired (expired)
    );

    // Match is checked before the timer so a same-cycle hit reports success.
    always_comb begin
        state_nx   = state;
        timeout_nx = 1'b0;
        case (state)
            IDLE: if (accept) state_nx = LOAD;
            LOAD: state_nx = bus.abort ? IDLE : RUN;
            RUN: begin
                if (bus.abort)
                    state_nx = IDLE;
                else if (match)
                    state_nx = DONE;
                else if (expired) begin
                    state_nx   = DONE;
                    timeout_nx = 1'b1;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are flops, not gates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            preset_q    <= '0;
            target_q    <= '0;
            bus.load    <= 1'b0;
            bus.d       <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            bus.load    <= (state_nx == LOAD);
            bus.busy    <= (state_nx == LOAD) || (state_nx == RUN);
            bus.done    <= (state_nx == DONE);
            bus.timeout <= timeout_nx;
            if (accept) begin
                preset_q <= bus.preset;
                target_q <= bus.target;
                bus.d    <= bus.preset;
            end
        end
    end
endmodule

// File: tb/tb_load_sequencer.sv
// Directed scenarios against a behavioural loadable counter; a monitor
// checks load and done pulses against a scoreboard of expected events.
module tb_load_sequencer;
    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    logic clk;
    logic rst;
    logic cnt_rst;
    int   cyc;
    int   total;
    int   bad;
    exp_t lq[$];
    exp_t dq[$];

    load_sequencer_if #(.WIDTH(4)) bus ();

    load_sequencer #(.WIDTH(4), .TIMEOUT(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cnt_rst)
            bus.count <= 4'd0;
        else if (bus.load)
            bus.count <= bus.d;
        else
            bus.count <= bus.count + 4'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.load === 1'b1) begin
                if (lq.size() == 0)
                    check("load_unexpected", 32'(bus.load), 32'd0);
                else begin
                    e = lq.pop_front();
                    check("load_cycle", 32'(cyc), 32'(e.cyc));
                    check("load_d", 32'(bus.d), 32'(e.val));
                end
            end
            if (bus.done === 1'b1) begin
                if (dq.size() == 0)
                    check("done_unexpected", 32'(bus.done), 32'd0);
                else begin
                    e = dq.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("done_timeout", 32'(bus.timeout), 32'(e.val));
                end
            end
        end
    endtask

    task automatic start_op(input logic [3:0] p, input logic [3:0] t, input int off,
                            input logic to, output int e0);
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.preset      = p;
        bus.target      = t;
        @(posedge clk);
        #1;
        e0 = cyc;
        bus.start_valid = 1'b0;
        lq.push_back('{e0, p});
        if (off > 0) dq.push_back('{e0 + off, {3'b000, to}});
    endtask

    task automatic drain();
        int n = 0;
        while (dq.size() != 0 && n < 60) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("drain_done_queue", 32'(dq.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_load"}, 32'(bus.load), 32'd0);
        check({tag, "_d"}, 32'(bus.d), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_ready"}, 32'(bus.start_ready), 32'd1);
    endtask

    initial begin
        int e0;
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst             = 1'b1;
        cnt_rst         = 1'b1;
        bus.start_valid = 1'b0;
        bus.preset      = 4'd0;
        bus.target      = 4'd0;
        bus.abort       = 1'b0;

        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog act=running exp=finished");
                $fatal(1, "watchdog expired");
            end
        join_none

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst     = 1'b0;
        cnt_rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(bus.start_ready), 32'd1);

        // Plain run, wrapped run, and immediate match.
        start_op(4'd3, 4'd7, 6, 1'b0, e0);
        drain();
        start_op(4'd13, 4'd2, 7, 1'b0, e0);
        drain();
        start_op(4'd9, 4'd9, 2, 1'b0, e0);
        drain();

        // Stalled counter: no match, so the run ends on the timer.
        cnt_rst = 1'b1;
        start_op(4'd2, 4'd5, 21, 1'b1, e0);
        drain();
        cnt_rst = 1'b0;

        // Abort during the third RUN cycle.
        start_op(4'd0, 4'd10, 0, 1'b0, e0);
        repeat (4) @(negedge clk);
        check("abort_cycle", 32'(cyc), 32'(e0 + 3));
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_ready", 32'(bus.start_ready), 32'd1);
        repeat (12) @(negedge clk);
        start_op(4'd0, 4'd1, 3, 1'b0, e0);
        drain();

        // Reset mid-RUN with a start request held across the release.
        start_op(4'd1, 4'd15, 0, 1'b0, e0);
        repeat (4) @(negedge clk);
        bus.start_valid = 1'b1;
        bus.preset      = 4'd4;
        bus.target      = 4'd6;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_midrun_rst", 32'(bus.start_ready), 32'd1);
        @(posedge clk);
        #1;
        e0 = cyc;
        bus.start_valid = 1'b0;
        lq.push_back('{e0, 4'd4});
        dq.push_back('{e0 + 4, 4'd0});
        drain();

        repeat (5) @(negedge clk);
        check("load_queue_empty", 32'(lq.size()), 32'd0);
        check("done_queue_empty", 32'(dq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
